vend_change_fsm: RTL and testbench



---
 rtl/vend_change_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_vend_change_fsm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_fsm.sv
// Vend controller: BCD price check, product release, greedy change dispenser.
// Define DISPENSE_GAP_EN to hold GAP_CYCLES idle cycles between coin pulses.
module vend_change_fsm #(
  parameter int INIT_CNT_10  = 5,
  parameter int INIT_CNT_20  = 5,
  parameter int INIT_CNT_50  = 5,
  parameter int INIT_CNT_100 = 5,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] price_msb,
  input  logic [3:0] price_lsb,
  input  logic       price_valid,
  input  logic [3:0] money_msb,
  input  logic [3:0] money_lsb,
  input  logic       vend_req,
  input  logic       cancel,
  input  logic [3:0] coin_in,
  output logic       product_out,
  output logic [3:0] coin_out,
  output logic [3:0] change_msb,
  output logic [3:0] change_lsb,
  output logic       busy,
  output logic       reject,
  output logic       done,
  output logic       clear_total,
  output logic       change_fault,
  output logic [3:0] inv_10,
  output logic [3:0] inv_20,
  output logic [3:0] inv_50,
  output logic [3:0] inv_100
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_VEND, S_CHANGE, S_DONE, S_FAULT
  } state_t;

  localparam logic [15:0] INIT_V = {
    4'(INIT_CNT_100), 4'(INIT_CNT_50),
    4'(INIT_CNT_20), 4'(INIT_CNT_10)
  };

  state_t     state, state_nx;
  logic [3:0] pm_r, pl_r, mm_r, ml_r;
  logic       pv_r;
  logic [6:0] rem;
  logic [3:0] inv [4];

  logic [6:0] money_v, money_l, price_l;
  logic       money_ok, lat_ok, chk_fail;
  logic [3:0] sel, dec;
  logic [6:0] sel_val;
  logic       dispense, gap_busy;

  assign money_v  = 7'(money_msb) * 7'd10 + 7'(money_lsb);
  assign money_ok = (money_msb <= 4'd9) && (money_lsb <= 4'd9);
  assign money_l  = 7'(mm_r) * 7'd10 + 7'(ml_r);
  assign price_l  = 7'(pm_r) * 7'd10 + 7'(pl_r);
  assign lat_ok   = (mm_r <= 4'd9) && (ml_r <= 4'd9) &&
                    (pm_r <= 4'd9) && (pl_r <= 4'd9);
  assign chk_fail = !pv_r || !lat_ok || (money_l < price_l);

  // Greedy pick: largest coin that fits the amount owed and is in stock.
  always_comb begin
    sel     = 4'b0000;
    sel_val = 7'd0;
    if (rem >= 7'd10 && inv[3] != 4'd0) begin
      sel = 4'b1000; sel_val = 7'd10;
    end else if (rem >= 7'd5 && inv[2] != 4'd0) begin
      sel = 4'b0100; sel_val = 7'd5;
    end else if (rem >= 7'd2 && inv[1] != 4'd0) begin
      sel = 4'b0010; sel_val = 7'd2;
    end else if (rem >= 7'd1 && inv[0] != 4'd0) begin
      sel = 4'b0001; sel_val = 7'd1;
    end
  end

  assign dispense = (state == S_CHANGE) && !gap_busy &&
                    (sel != 4'b0000);
  assign dec = dispense ? sel : 4'b0000;

`ifdef DISPENSE_GAP_EN
  logic [7:0] gap;
  always_ff @(posedge clk) begin
    if (reset)
      gap <= 8'd0;
    else if (dispense && rem != sel_val)
      gap <= 8'(GAP_CYCLES);
    else if (gap != 8'd0)
      gap <= gap - 8'd1;
  end
  assign gap_busy = (gap != 8'd0);
`else
  assign gap_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cancel) begin
          if (money_ok && money_v != 7'd0)
            state_nx = S_CHANGE;
        end else if (vend_req) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK:  state_nx = chk_fail ? S_IDLE : S_VEND;
      S_VEND:   state_nx = (rem == 7'd0) ? S_DONE : S_CHANGE;
      S_CHANGE: begin
        if (!gap_busy) begin
          if (sel == 4'b0000)
            state_nx = S_FAULT;
          else if (rem == sel_val)
            state_nx = S_DONE;
        end
      end
      S_DONE:   state_nx = S_IDLE;
      S_FAULT:  if (cancel) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pm_r <= 4'd0; pl_r <= 4'd0;
      mm_r <= 4'd0; ml_r <= 4'd0;
      pv_r <= 1'b0;
      rem  <= 7'd0;
    end else begin
      if (state == S_IDLE && vend_req && !cancel) begin
        pm_r <= price_msb; pl_r <= price_lsb;
        mm_r <= money_msb; ml_r <= money_lsb;
        pv_r <= price_valid;
      end
      if (state == S_IDLE && cancel && money_ok &&
          money_v != 7'd0)
        rem <= money_v;
      else if (state == S_CHECK && !chk_fail)
        rem <= money_l - price_l;
      else if (dispense)
        rem <= rem - sel_val;
      else if (state == S_FAULT && cancel)
        rem <= 7'd0;
    end
  end

  // Simultaneous insert and dispense of one coin type cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)
        inv[i] <= INIT_V[4*i +: 4];
      else if (coin_in[i] != dec[i]) begin
        if (coin_in[i]) begin
          if (inv[i] != 4'd15)
            inv[i] <= inv[i] + 4'd1;
        end else begin
          inv[i] <= inv[i] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    product_out = 1'b0;
    coin_out    = 4'b0000;
    reject      = 1'b0;
    done        = 1'b0;
    clear_total = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (cancel) begin
            if (!money_ok)
              reject = 1'b1;
            else if (money_v == 7'd0)
              done = 1'b1;
          end
        end
        S_CHECK:  reject = chk_fail;
        S_VEND:   product_out = 1'b1;
        S_CHANGE: coin_out = dec;
        S_DONE: begin
          done        = 1'b1;
          clear_total = 1'b1;
        end
        S_FAULT:  clear_total = cancel;
        default: ;
      endcase
    end
  end

  assign change_fault = (state == S_FAULT);
  assign busy         = (state != S_IDLE);
  assign change_msb   = 4'(rem / 7'd10);
  assign change_lsb   = 4'(rem % 7'd10);

  assign inv_10  = inv[0];
  assign inv_20  = inv[1];
  assign inv_50  = inv[2];
  assign inv_100 = inv[3];

endmodule

// File: tb/tb_vend_change_fsm.sv
// Bench for vend_change_fsm: directed steps then random transactions,
// each checked against a greedy change model built from plain arithmetic.
module tb_vend_change_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] price_msb, price_lsb, money_msb, money_lsb, coin_in;
  logic       price_valid, vend_req, cancel;
  logic       product_out, busy, reject, done, clear_total, change_fault;
  logic [3:0] coin_out, change_msb, change_lsb;
  logic [3:0] inv_10, inv_20, inv_50, inv_100;

  int checks = 0;
  int failures = 0;
  localparam int GAP = 2;

  typedef struct packed {
    logic        vend;
    logic        can;
    logic [3:0]  ci;
    logic [17:0] o;
  } rec_t;

  rec_t q[$];
  int   minv [4];
  int   cval [4] = '{1, 2, 5, 10};
  bit   noise = 1'b0;

  logic [17:0] obs;
  assign obs = {busy, product_out, coin_out, reject, done, clear_total,
                change_fault, change_msb, change_lsb};

  vend_change_fsm dut (
    .clk(clk), .reset(reset),
    .price_msb(price_msb), .price_lsb(price_lsb),
    .price_valid(price_valid),
    .money_msb(money_msb), .money_lsb(money_lsb),
    .vend_req(vend_req), .cancel(cancel), .coin_in(coin_in),
    .product_out(product_out), .coin_out(coin_out),
    .change_msb(change_msb), .change_lsb(change_lsb),
    .busy(busy), .reject(reject), .done(done),
    .clear_total(clear_total), .change_fault(change_fault),
    .inv_10(inv_10), .inv_20(inv_20),
    .inv_50(inv_50), .inv_100(inv_100)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(bit b, bit p, logic [3:0] c,
                                     bit r, bit d, bit cl, bit f,
                                     int chg);
    logic [3:0] hi, lo;
    hi = 4'(chg / 10);
    lo = 4'(chg % 10);
    return {b, p, c, r, d, cl, f, hi, lo};
  endfunction

  function automatic logic rn();
    return noise ? 1'($urandom % 2) : 1'b0;
  endfunction

  function automatic rec_t rc(logic v, logic cn, logic [17:0] o);
    rec_t r;
    r.vend = v; r.can = cn; r.ci = 4'b0000; r.o = o;
    return r;
  endfunction

  function automatic logic [17:0] idle();
    return mk(0, 0, 4'b0, 0, 0, 0, 0, 0);
  endfunction

  // Pay out 'owed' greedily from the model inventory, or end in a fault.
  function automatic void add_change(int owed);
    int pick;
    while (owed > 0) begin
      pick = -1;
      for (int i = 3; i >= 0; i--)
        if (pick < 0 && cval[i] <= owed && minv[i] > 0) pick = i;
      if (pick < 0) begin
        q.push_back(rc(rn(), rn(), mk(1, 0, 4'b0, 0, 0, 0, 0, owed)));
        q.push_back(rc(0, 0, mk(1, 0, 4'b0, 0, 0, 0, 1, owed)));
        q.push_back(rc(rn(), 0, mk(1, 0, 4'b0, 0, 0, 0, 1, owed)));
        q.push_back(rc(0, 1, mk(1, 0, 4'b0, 0, 0, 1, 1, owed)));
        q.push_back(rc(0, 0, idle()));
        return;
      end
      q.push_back(rc(rn(), rn(),
                     mk(1, 0, 4'(1 << pick), 0, 0, 0, 0, owed)));
      minv[pick]--;
      owed -= cval[pick];
`ifdef DISPENSE_GAP_EN
      if (owed > 0)
        repeat (GAP)
          q.push_back(rc(rn(), rn(), mk(1, 0, 4'b0, 0, 0, 0, 0, owed)));
`endif
    end
    q.push_back(rc(rn(), rn(), mk(1, 0, 4'b0, 0, 1, 1, 0, 0)));
    q.push_back(rc(0, 0, idle()));
  endfunction

  function automatic void m_vend(int pm, int pl, int pv, int mm, int ml);
    int p, m;
    p = pm * 10 + pl;
    m = mm * 10 + ml;
    q.push_back(rc(1, 0, idle()));
    if (pm > 9 || pl > 9 || mm > 9 || ml > 9 || pv == 0 || m < p) begin
      q.push_back(rc(rn(), rn(), mk(1, 0, 4'b0, 1, 0, 0, 0, 0)));
      q.push_back(rc(0, 0, idle()));
    end else begin
      q.push_back(rc(rn(), rn(), mk(1, 0, 4'b0, 0, 0, 0, 0, 0)));
      q.push_back(rc(rn(), rn(), mk(1, 1, 4'b0, 0, 0, 0, 0, m - p)));
      add_change(m - p);
    end
  endfunction

  function automatic void m_cancel(int mm, int ml);
    int m;
    m = mm * 10 + ml;
    if (mm > 9 || ml > 9) begin
      q.push_back(rc(0, 1, mk(0, 0, 4'b0, 1, 0, 0, 0, 0)));
      q.push_back(rc(0, 0, idle()));
    end else if (m == 0) begin
      q.push_back(rc(0, 1, mk(0, 0, 4'b0, 0, 1, 0, 0, 0)));
      q.push_back(rc(0, 0, idle()));
    end else begin
      q.push_back(rc(0, 1, idle()));
      add_change(m);
    end
  endfunction

  function automatic void m_coins(logic [3:0] ci, int n);
    rec_t r;
    for (int k = 0; k < n; k++) begin
      r = rc(0, 0, idle());
      r.ci = ci;
      q.push_back(r);
      for (int i = 0; i < 4; i++)
        if (ci[i] && minv[i] < 15) minv[i]++;
    end
    q.push_back(rc(0, 0, idle()));
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_inv(string tag);
    chk({tag, ".inv"}, 32'({inv_100, inv_50, inv_20, inv_10}),
        32'({4'(minv[3]), 4'(minv[2]), 4'(minv[1]), 4'(minv[0])}));
  endtask

  task automatic run(string tag);
    rec_t r;
    int   n;
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      vend_req = r.vend;
      cancel   = r.can;
      coin_in  = r.ci;
      #1;
      chk($sformatf("%s.c%0d", tag, n), 32'(obs), 32'(r.o));
      n++;
    end
    chk_inv(tag);
  endtask

  task automatic t_vend(string tag, int pm, int pl, int pv,
                        int mm, int ml);
    price_msb = 4'(pm); price_lsb = 4'(pl);
    price_valid = 1'(pv);
    money_msb = 4'(mm); money_lsb = 4'(ml);
    m_vend(pm, pl, pv, mm, ml);
    run(tag);
  endtask

  task automatic t_cancel(string tag, int mm, int ml);
    money_msb = 4'(mm); money_lsb = 4'(ml);
    m_cancel(mm, ml);
    run(tag);
  endtask

  function automatic int dig();
    return ($urandom % 10 == 0) ? int'($urandom % 16)
                                : int'($urandom % 10);
  endfunction

  initial begin
    rec_t t;
    int   p, m;
    reset = 1'b1;
    price_msb = 0; price_lsb = 0; price_valid = 1'b1;
    money_msb = 0; money_lsb = 0;
    vend_req = 0; cancel = 0; coin_in = 0;
    for (int i = 0; i < 4; i++) minv[i] = 5;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.out", 32'(obs), 32'(idle()));
    chk_inv("reset");

    t_vend("v12_20", 1, 2, 1, 2, 0);
    t_vend("rej27_25", 2, 7, 1, 2, 5);
    t_cancel("can17", 1, 7);
    t_vend("exact08", 0, 8, 1, 0, 8);
    t_cancel("can00", 0, 0);
    t_vend("pv0", 0, 1, 0, 9, 9);
    t_vend("bcd_p", 0, 10, 1, 5, 0);
    t_cancel("bcd_m", 12, 0);

    // Insert a 10 sen coin on the very cycle one is paid out.
    money_msb = 0; money_lsb = 1;
    m_cancel(0, 1);
    t = q[1];
    t.ci = 4'b0001;
    q[1] = t;
    minv[0]++;
    run("same_cyc");

    repeat (4) t_cancel("drain10", 0, 1);
    t_vend("fault06", 0, 5, 1, 0, 6);
    t_vend("fault60", 0, 0, 1, 0, 6);

    m_coins(4'b0001, 17);
    run("sat10");
    m_coins(4'b1111, 3);
    run("multi");

    // Reset while change is still being paid out.
    money_msb = 9; money_lsb = 9;
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rst_mid.pulse",
        32'({product_out, coin_out, reject, done, clear_total}), 32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) minv[i] = 5;
    chk("rst_mid.out", 32'(obs), 32'(idle()));
    chk_inv("rst_mid");

    noise = 1'b1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom % 6)
        0, 1, 2: t_vend($sformatf("rv%0d", it), dig(), dig(),
                        int'($urandom % 10 != 0), dig(), dig());
        3: t_cancel($sformatf("rc%0d", it), dig(), dig());
        4: begin
          m_coins(4'($urandom % 16), 1 + int'($urandom % 3));
          run($sformatf("ri%0d", it));
        end
        default: begin
          p = int'($urandom % 100);
          m = p + int'($urandom % 30);
          if (m > 99) m = 99;
          t_vend($sformatf("rg%0d", it), p / 10, p % 10, 1,
                 m / 10, m % 10);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
